// File: rtl/vx_gbar_arbiter.sv
// ---------------------------------------------------------------------------
// vx_gbar_arbiter
//
// Global barrier arbiter. Cores announce arrival at a barrier id; one arrival
// is granted per cycle with round-robin priority. Each barrier tracks which
// cores have arrived and how many participants it expects (size_m1 + 1,
// latched from the first arrival). When the last expected core arrives the
// barrier is cleared and a one-cycle release pulse is broadcast the next
// cycle.
//
// Ports
//   clk          in   1                     rising-edge clock
//   reset_n      in   1                     asynchronous active-low reset
//   req_valid    in   NUM_CORES             per-core arrival request
//   req_id       in   NUM_CORES*NB_WIDTH    per-core barrier id (core i at [i*NB_WIDTH +: NB_WIDTH])
//   req_size_m1  in   NUM_CORES*NC_WIDTH    per-core participant count minus one
//   req_ready    out  NUM_CORES             one-hot grant (combinational)
//   rsp_valid    out  1                     single-cycle release pulse
//   rsp_id       out  NB_WIDTH              id of released barrier
//   busy         out  1                     any barrier holds a recorded arrival
//   err          out  1                     sticky protocol-error flag
// ---------------------------------------------------------------------------
module vx_gbar_arbiter #(
  parameter int  NUM_CORES    = 4,
  parameter int  NUM_BARRIERS = 4,
  localparam int NC_WIDTH     = (NUM_CORES    > 1) ? $clog2(NUM_CORES)    : 1,
  localparam int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CORES-1:0]            req_valid,
  input  logic [NUM_CORES*NB_WIDTH-1:0]   req_id,
  input  logic [NUM_CORES*NC_WIDTH-1:0]   req_size_m1,
  output logic [NUM_CORES-1:0]            req_ready,
  output logic                            rsp_valid,
  output logic [NB_WIDTH-1:0]             rsp_id,
  output logic                            busy,
  output logic                            err
);

  localparam logic [NC_WIDTH:0] CNT_ONE = (NC_WIDTH+1)'(1);

  // Architectural state
  logic [NC_WIDTH-1:0]  r_last_grant;
  logic [NUM_CORES-1:0] r_mask [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  r_size [NUM_BARRIERS];
  logic                 r_rsp_valid;
  logic [NB_WIDTH-1:0]  r_rsp_id;
  logic                 r_err;

  // Per-core views of the flattened request buses
  logic [NB_WIDTH-1:0]  w_req_id   [NUM_CORES];
  logic [NC_WIDTH-1:0]  w_req_size [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign w_req_id[g]   = req_id[g*NB_WIDTH +: NB_WIDTH];
    assign w_req_size[g] = req_size_m1[g*NC_WIDTH +: NC_WIDTH];
  end

  // Round-robin arbitration
  logic                 w_found;
  logic [NC_WIDTH-1:0]  w_grant_idx;
  logic [NUM_CORES-1:0] w_ready;

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    logic [NC_WIDTH-1:0] cand;
    w_found     = 1'b0;
    w_grant_idx = '0;
    cand        = '0;
    // Search starts just past the last winner and wraps, so the previous
    // winner has the lowest priority this cycle.
    for (int off = 1; off <= NUM_CORES; off++) begin
      cand = NC_WIDTH'((int'(r_last_grant) + off) % NUM_CORES);
      if (!w_found && req_valid[cand]) begin
        w_found     = 1'b1;
        w_grant_idx = cand;
      end
    end
    w_ready = w_found ? (NUM_CORES'(1) << w_grant_idx) : '0;
  end

  // Barrier bookkeeping for the granted request
  logic [NB_WIDTH-1:0]  w_id;
  logic [NC_WIDTH-1:0]  w_size;
  logic                 w_id_ok;
  logic [NUM_CORES-1:0] w_cur_mask;
  logic [NUM_CORES-1:0] w_core_bit;
  logic [NUM_CORES-1:0] w_new_mask;
  logic [NC_WIDTH:0]    w_count;
  logic [NC_WIDTH:0]    w_target;
  logic                 w_first;
  logic                 w_dup;
  logic                 w_size_err;
  logic                 w_release;
  logic                 w_busy;

  always_comb begin
    w_id       = w_req_id[w_grant_idx];
    w_size     = w_req_size[w_grant_idx];
    w_id_ok    = (int'(w_id) < NUM_BARRIERS);
    w_cur_mask = w_id_ok ? r_mask[w_id] : '0;
    w_core_bit = NUM_CORES'(1) << w_grant_idx;
    w_first    = (w_cur_mask == '0);
    w_dup      = |(w_cur_mask & w_core_bit);
    w_new_mask = w_cur_mask | w_core_bit;

    // Popcount is one bit wider than a core index so a full barrier fits.
    w_count = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_count = w_count + {{NC_WIDTH{1'b0}}, w_new_mask[k]};
    end

    // The first arrival defines the participant count; later arrivals are
    // always measured against the latched value even if they disagree.
    w_target   = w_first ? ({1'b0, w_size} + CNT_ONE)
                         : ({1'b0, (w_id_ok ? r_size[w_id] : w_size)} + CNT_ONE);
    w_size_err = !w_first && w_id_ok && (w_size != r_size[w_id]);
    // A duplicate leaves the mask untouched, so it can never complete a barrier.
    w_release  = w_found && w_id_ok && !w_dup && (w_count == w_target);

    w_busy = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      w_busy = w_busy | (|r_mask[b]);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= NC_WIDTH'(NUM_CORES - 1);
      // NOTE: the barrier table is reset explicitly because a reset must
      // abandon partial episodes; it is small enough to live in flops.
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        r_mask[b] <= '0;
        r_size[b] <= '0;
      end
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_found) begin
        r_last_grant <= w_grant_idx;
        if (w_id_ok) begin
          if (w_first) begin
            r_size[w_id] <= w_size;
          end
          if (w_release) begin
            r_mask[w_id] <= '0;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_id;
          end else begin
            r_mask[w_id] <= w_new_mask;
          end
          if (w_dup || w_size_err) begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign busy      = w_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_vx_gbar_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vx_gbar_arbiter
//
// Drives directed barrier scenarios followed by random traffic into
// vx_gbar_arbiter and compares every cycle against a behavioural model that
// tracks, per barrier, which cores have arrived and how many are expected.
// ---------------------------------------------------------------------------
module tb_vx_gbar_arbiter;

  localparam int NC   = 4;
  localparam int NB   = 4;
  localparam int NC_W = 2;
  localparam int NB_W = 2;

  logic               clk;
  logic               reset_n;
  logic [NC-1:0]      req_valid;
  logic [NC*NB_W-1:0] req_id;
  logic [NC*NC_W-1:0] req_size_m1;
  logic [NC-1:0]      req_ready;
  logic               rsp_valid;
  logic [NB_W-1:0]    rsp_id;
  logic               busy;
  logic               err;

  vx_gbar_arbiter #(
    .NUM_CORES    (NC),
    .NUM_BARRIERS (NB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_size_m1 (req_size_m1),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_last;               // core that won most recently
  bit m_arrived [NB][NC];   // which cores have arrived at each barrier
  int m_need    [NB];       // participants expected in the current episode
  bit m_rsp_valid;
  int m_rsp_id;
  bit m_err;

  function automatic void model_reset();
    m_last      = NC - 1;
    m_rsp_valid = 1'b0;
    m_rsp_id    = 0;
    m_err       = 1'b0;
    for (int b = 0; b < NB; b++) begin
      m_need[b] = 0;
      for (int c = 0; c < NC; c++) m_arrived[b][c] = 1'b0;
    end
  endfunction

  function automatic int arrivals(input int b);
    int n = 0;
    for (int c = 0; c < NC; c++) n += int'(m_arrived[b][c]);
    return n;
  endfunction

  function automatic bit model_busy();
    for (int b = 0; b < NB; b++) if (arrivals(b) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Winner: first requesting core after the previous winner, wrapping.
  function automatic int model_winner(input logic [NC-1:0] v);
    for (int k = 1; k <= NC; k++) begin
      int c = (m_last + k) % NC;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_accept(input int c, input int id, input int s);
    int n = arrivals(id);
    if (n == 0) m_need[id] = s + 1;
    else if (s + 1 != m_need[id]) m_err = 1'b1;
    if (m_arrived[id][c]) begin
      m_err = 1'b1;
      return;
    end
    m_arrived[id][c] = 1'b1;
    if (n + 1 == m_need[id]) begin
      for (int k = 0; k < NC; k++) m_arrived[id][k] = 1'b0;
      m_rsp_valid = 1'b1;
      m_rsp_id    = id;
    end
  endfunction

  // One clock cycle: called at a falling edge, drives inputs, checks all
  // outputs against the model, advances the model, waits for the next falling edge.
  task automatic step(input logic [NC-1:0] v, input logic [NC*NB_W-1:0] ids,
                      input logic [NC*NC_W-1:0] sz, output logic [NC-1:0] g);
    int w;
    logic [NC-1:0] exp_g;
    req_valid   = v;
    req_id      = ids;
    req_size_m1 = sz;
    #1;
    w     = model_winner(v);
    exp_g = (w < 0) ? '0 : (NC'(1) << w);
    check("req_ready", 32'(req_ready), 32'(exp_g));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid) check("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
    check("busy", 32'(busy), 32'(model_busy()));
    check("err", 32'(err), 32'(m_err));
    g = req_ready;
    m_rsp_valid = 1'b0;
    if (w >= 0) begin
      model_accept(w, int'(ids[w*NB_W +: NB_W]), int'(sz[w*NC_W +: NC_W]));
      m_last = w;
    end
    @(negedge clk);
  endtask

  task automatic req1(input int core, input int id, input int sz);
    logic [NC-1:0]      v   = '0;
    logic [NC*NB_W-1:0] ids = '0;
    logic [NC*NC_W-1:0] szs = '0;
    logic [NC-1:0]      g;
    v[core] = 1'b1;
    ids[core*NB_W +: NB_W] = NB_W'(id);
    szs[core*NC_W +: NC_W] = NC_W'(sz);
    step(v, ids, szs, g);
  endtask

  task automatic idle();
    logic [NC-1:0] g;
    step('0, '0, '0, g);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [NC-1:0]      v;
    logic [NC-1:0]      g;
    logic [NC*NB_W-1:0] ids;
    logic [NC*NC_W-1:0] szs;
    int                 size_tab [NB];

    reset_n     = 1'b0;
    req_valid   = '0;
    req_id      = '0;
    req_size_m1 = '0;
    model_reset();
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready_idle", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Cores 0..3 arrive one after another at barrier 1 of size 4.
    req1(0, 1, 3);
    check("seq_busy_partial", 32'(busy), 32'd1);
    req1(1, 1, 3);
    req1(2, 1, 3);
    req1(3, 1, 3);
    check("seq_rsp_valid", 32'(rsp_valid), 32'd1);
    check("seq_rsp_id", 32'(rsp_id), 32'd1);
    check("seq_busy_done", 32'(busy), 32'd0);
    idle();

    // All four request together; grants must rotate 0,1,2,3.
    v   = '1;
    ids = {NB_W'(2), NB_W'(2), NB_W'(2), NB_W'(2)};
    szs = {NC_W'(3), NC_W'(3), NC_W'(3), NC_W'(3)};
    for (int k = 0; k < NC; k++) begin
      step(v, ids, szs, g);
      check("all_grant", 32'(g), 32'(NC'(1) << k));
      v = v & ~g;
    end
    check("all_rsp_valid", 32'(rsp_valid), 32'd1);
    check("all_rsp_id", 32'(rsp_id), 32'd2);
    idle();

    // Single-participant barrier releases immediately.
    req1(2, 0, 0);
    check("solo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("solo_rsp_id", 32'(rsp_id), 32'd0);
    check("solo_busy", 32'(busy), 32'd0);
    idle();

    // Duplicate arrival flags err without progressing the barrier.
    req1(1, 3, 1);
    req1(1, 3, 1);
    check("dup_err", 32'(err), 32'd1);
    check("dup_no_rsp", 32'(rsp_valid), 32'd0);
    req1(0, 3, 1);
    check("dup_rsp_valid", 32'(rsp_valid), 32'd1);
    check("dup_rsp_id", 32'(rsp_id), 32'd3);
    idle();

    // Reset in the middle of a partial barrier discards it.
    req1(0, 1, 2);
    req1(1, 1, 2);
    req_valid = 4'b0110;
    req_id    = {NB_W'(1), NB_W'(1), NB_W'(1), NB_W'(1)};
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    reset_n = 1'b1;
    req1(2, 1, 2);
    check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    idle();

    // Interleaved barriers 0 and 1 complete independently.
    do_reset();
    req1(0, 0, 1);
    req1(1, 1, 1);
    req1(2, 0, 1);
    check("ilv_rsp0_valid", 32'(rsp_valid), 32'd1);
    check("ilv_rsp0_id", 32'(rsp_id), 32'd0);
    req1(3, 1, 1);
    check("ilv_rsp1_valid", 32'(rsp_valid), 32'd1);
    check("ilv_rsp1_id", 32'(rsp_id), 32'd1);
    check("ilv_err", 32'(err), 32'd0);
    idle();

    // Random traffic; sizes mostly consistent per barrier so releases occur.
    do_reset();
    for (int b = 0; b < NB; b++) size_tab[b] = $urandom_range(0, NC - 1);
    for (int n = 0; n < 500; n++) begin
      v = NC'($urandom_range(0, (1 << NC) - 1));
      for (int c = 0; c < NC; c++) begin
        int id = $urandom_range(0, NB - 1);
        ids[c*NB_W +: NB_W] = NB_W'(id);
        szs[c*NC_W +: NC_W] = ($urandom_range(0, 15) == 0)
                              ? NC_W'($urandom_range(0, NC - 1))
                              : NC_W'(size_tab[id]);
      end
      step(v, ids, szs, g);
      if (n % 100 == 99) begin
        do_reset();
        for (int b = 0; b < NB; b++) size_tab[b] = $urandom_range(0, NC - 1);
      end
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
